// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier -- unsigned 8x8 -> 16-bit sequential multiplier (MULTU path).
// One eightbit_adder is reused over 8 shift-add steps. The result feeds the
// HI/LO registers downstream. Only one operation is in flight at a time.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-high reset
//   start         in   request, sampled only while idle
//   multiplicand  in   operand M, captured on the accepted start edge
//   multiplier    in   operand Q, captured on the accepted start edge
//   busy          out  high whenever the FSM is not idle
//   done          out  one-cycle pulse; product is valid in the same cycle
//   product       out  {HI, LO} of M*Q, held until the next done

// eightbit_adder -- 8-bit ripple adder with carry in/out.
// Ports: in_1, in_2 (addends), c_in (carry in), sum, c_out (carry out).
module eightbit_adder (
   input  logic [7:0] in_1,
   input  logic [7:0] in_2,
   input  logic       c_in,
   output logic [7:0] sum,
   output logic       c_out
);
   assign {c_out, sum} = {1'b0, in_1} + {1'b0, in_2} + {8'b0, c_in};
endmodule

module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // The datapath is a single eightbit_adder, so no other width can work.
   if (WIDTH != 8) begin : g_width_check
      $error("shift_add_multiplier: WIDTH must be 8");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [2:0]       cnt;

   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] q_next;
   logic             last_step;

   eightbit_adder u_adder (
      .in_1  (a),
      .in_2  (add_b),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (c_out)
   );

   // The carry of each step is shifted straight into A[7], and the register
   // above A is always zero after the shift, so no separate carry flop is kept.
   always_comb begin
      add_b  = q[0] ? m : '0;
      a_next = '0;
      q_next = '0;
      if (q[0]) begin
         a_next = {c_out, sum[WIDTH-1:1]};
         q_next = {sum[0], q[WIDTH-1:1]};
      end else begin
         a_next = {1'b0, a[WIDTH-1:1]};
         q_next = {a[0], q[WIDTH-1:1]};
      end
   end

   assign last_step = (cnt == 3'd7);

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (last_step) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a       <= '0;
         q       <= '0;
         m       <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m   <= multiplicand;
                  q   <= multiplier;
                  a   <= '0;
                  cnt <= '0;
               end
            end
            CALC: begin
               a   <= a_next;
               q   <= q_next;
               cnt <= cnt + 3'd1;
               if (last_step) product <= {a_next, q_next};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [15:0] prod;
      int          at;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   shift_add_multiplier #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every done pulse pops one expectation and checks value and timing.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 with product %0h, required no done (t=%0t)",
                     product, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", product, e.prod);
            check("done_cycle", cyc, e.at);
         end
      end
   end

   // Start is accepted at the next edge; returns the cycle count after that edge.
   task automatic issue(input logic [7:0] mv, input logic [7:0] qv, output int c0);
      start        = 1'b1;
      multiplicand = mv;
      multiplier   = qv;
      @(posedge clk);
      #1;
      start = 1'b0;
      c0    = cyc;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   task automatic run_op(input logic [7:0] mv, input logic [7:0] qv,
                         input logic [15:0] expv, input logic [15:0] prev);
      int c0;
      issue(mv, qv, c0);
      sb.push_back('{prod: expv, at: c0 + 8});
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         check("busy_window", busy, (k <= 8) ? 1 : 0);
         if (k < 8) check("product_stable", product, prev);
      end
      @(posedge clk);
      #1;
      check("product_held", product, expv);
   endtask

   initial begin
      int c0;
      rst          = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      #1;
      rst = 1'b1;
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_product", product, 16'h0000);
      #19;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(8'd13,  8'd11,  16'h008F, 16'h0000);
      run_op(8'd255, 8'd255, 16'hFE01, 16'h008F);
      run_op(8'd128, 8'd2,   16'h0100, 16'hFE01);
      run_op(8'd0,   8'd200, 16'h0000, 16'h0100);
      run_op(8'd200, 8'd0,   16'h0000, 16'h0000);

      // 7*9 in flight; start with 50*50 raised at step 3 and held to E10.
      issue(8'd7, 8'd9, c0);
      sb.push_back('{prod: 16'h003F, at: c0 + 8});
      sb.push_back('{prod: 16'h09C4, at: c0 + 18});
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      start        = 1'b1;
      multiplicand = 8'd50;
      multiplier   = 8'd50;
      while (cyc < c0 + 10) begin
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("second_op_busy", busy, 1);
      wait_idle();
      check("second_op_product", product, 16'h09C4);

      // 100*100 aborted by reset after step 4.
      issue(8'd100, 8'd100, c0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_product", product, 16'h0000);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      check("abort_idle", busy, 0);
      check("abort_product_after", product, 16'h0000);

      run_op(8'd3, 8'd5, 16'h000F, 16'h0000);

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
